// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus: instruction-memory request/response plus the decode-side
// instruction handoff and the branch/jump controls sampled at acceptance.
interface ifu_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        Branch;
    logic        Jump;
    logic        Zero;

    // The fetch unit drives requests and the presented instruction.
    modport master (
        output imem_req, imem_addr, instr, op, pc_plus4, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, Branch, Jump, Zero
    );

    // Memory and decode/execute side.
    modport slave (
        input  imem_req, imem_addr, instr, op, pc_plus4, instr_valid,
        output imem_ack, imem_rdata, instr_ready, Branch, Jump, Zero
    );
endinterface

// File: rtl/ifu_fetch.sv
// Two-state instruction fetch unit: FETCH issues a memory read, ISSUE holds
// the instruction until decode accepts it. Optional IFU_PERF_CNT_EN adds fetch_count.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    ifu_fetch_if.master bus
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    // Word alignment is enforced on the reset address so imem_addr[1:0] is always 0.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;

    logic        accept;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] next_pc;

    assign accept = (state_q == S_ISSUE) && bus.instr_ready;

    // Targets derive from the held instruction, so they are stable for the whole ISSUE phase.
    assign jump_target   = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
    assign branch_target = pc_plus4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4_q;
        if (bus.Jump) begin
            next_pc = jump_target;
        end else if (bus.Branch && bus.Zero) begin
            next_pc = branch_target;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ack) begin
                    instr_d    = bus.imem_rdata;
                    pc_plus4_d = pc_q + 32'd4;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (accept) begin
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC_ALIGNED;
            instr_q    <= 32'd0;
            pc_plus4_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    // Handshake outputs are forced low while reset is held, even before the first reset edge.
    assign bus.imem_req    = (state_q == S_FETCH) && !reset;
    assign bus.instr_valid = (state_q == S_ISSUE) && !reset;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.op          = instr_q[31:26];
    assign bus.pc_plus4    = pc_plus4_q;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (accept) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed vectors, reset corner cases and
// randomized fetch/accept traffic against a next-PC reference model.
module tb_ifu_fetch;

    logic clk = 1'b0;
    logic reset = 1'b1;

    ifu_fetch_if bus ();

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    ifu_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_pc;
    logic [31:0] model_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        bit          b;
        bit          j;
        bit          z;
        int          rdy_dly;
        logic [31:0] exp_next;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Next fetch address from the architectural rules, using plain integer arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input bit b, input bit j, input bit z);
        logic [31:0] pp4;
        int          off;
        pp4 = pc + 32'd4;
        if (j) return (pp4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
        off = int'($signed(ins[15:0]));
        if (b && z) return pp4 + 32'(off * 4);
        return pp4;
    endfunction

    task automatic rand_ctrl();
        bus.Branch = 1'($urandom);
        bus.Jump   = 1'($urandom);
        bus.Zero   = 1'($urandom);
    endtask

    // One full fetch/issue/accept transaction; called and returning at a negedge.
    task automatic do_fetch(input logic [31:0] ins, input bit b, input bit j, input bit z,
                            input int ack_dly, input int rdy_dly, output logic [31:0] next_addr);
        int n;
        n = 0;
        next_addr = 32'hx;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.imem_req !== 1'b1) begin
            chk("req_timeout", {31'd0, bus.imem_req}, 32'd1);
            return;
        end
        chk("fetch_addr", bus.imem_addr, model_pc);
        for (int i = 0; i < ack_dly; i++) begin
            bus.imem_ack = 1'b0;
            rand_ctrl();
            @(negedge clk);
            chk("req_hold", {31'd0, bus.imem_req}, 32'd1);
            chk("addr_hold", bus.imem_addr, model_pc);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = ins;
        rand_ctrl();
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        chk("valid_after_ack", {31'd0, bus.instr_valid}, 32'd1);
        chk("req_in_issue", {31'd0, bus.imem_req}, 32'd0);
        chk("instr", bus.instr, ins);
        chk("op", {26'd0, bus.op}, {26'd0, ins[31:26]});
        chk("pc_plus4", bus.pc_plus4, model_pc + 32'd4);
        for (int i = 0; i < rdy_dly; i++) begin
            bus.instr_ready = 1'b0;
            bus.imem_ack    = 1'($urandom);
            rand_ctrl();
            @(negedge clk);
            chk("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
            chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
            chk("stall_instr", bus.instr, ins);
            chk("stall_pc_plus4", bus.pc_plus4, model_pc + 32'd4);
        end
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b1;
        bus.Branch      = b;
        bus.Jump        = j;
        bus.Zero        = z;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        bus.Branch      = 1'b0;
        bus.Jump        = 1'b0;
        bus.Zero        = 1'b0;
        model_pc  = ref_next(model_pc, ins, b, j, z);
        model_cnt = model_cnt + 32'd1;
        chk("req_after_accept", {31'd0, bus.imem_req}, 32'd1);
        chk("valid_after_accept", {31'd0, bus.instr_valid}, 32'd0);
        chk("next_addr", bus.imem_addr, model_pc);
        chk("addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);
`ifdef IFU_PERF_CNT_EN
        chk("fetch_count", fetch_count, model_cnt);
`endif
        next_addr = bus.imem_addr;
        $display("txn instr=%h b=%0d j=%0d z=%0d next_addr=%h", ins, b, j, z, next_addr);
    endtask

    // Walk the PC to an arbitrary address using jumps, crossing 256MB regions via region ends.
    task automatic goto_pc(input logic [31:0] target);
        logic [31:0] pp4;
        logic [31:0] t;
        logic [31:0] na;
        int          guard;
        guard = 0;
        while (model_pc != target && guard < 40) begin
            pp4 = model_pc + 32'd4;
            if (pp4[31:28] == target[31:28]) t = target;
            else                             t = {pp4[31:28], 28'hFFF_FFFC};
            do_fetch({6'b000010, t[27:2]}, 1'b0, 1'b1, 1'b0, 0, 0, na);
            guard++;
        end
        chk("goto_pc", model_pc, target);
    endtask

    vec_t        vecs[7];
    logic [31:0] na;

    initial begin
        vecs[0] = '{32'h0000_0010, 32'h1022_0003, 1'b1, 1'b0, 1'b1, 0, 32'h0000_0020};
        vecs[1] = '{32'h0000_0010, 32'h1022_0003, 1'b1, 1'b0, 1'b0, 0, 32'h0000_0014};
        vecs[2] = '{32'h4000_0000, 32'h0800_0040, 1'b0, 1'b1, 1'b0, 0, 32'h4000_0100};
        vecs[3] = '{32'h4000_0000, 32'h0800_0040, 1'b1, 1'b1, 1'b1, 0, 32'h4000_0100};
        vecs[4] = '{32'h0000_0100, 32'h1000_FFFF, 1'b1, 1'b0, 1'b1, 1, 32'h0000_0100};
        vecs[5] = '{32'h0000_0200, 32'h1000_0005, 1'b0, 1'b0, 1'b1, 2, 32'h0000_0204};
        vecs[6] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 5, 32'h0000_0000};

        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'd0;
        bus.instr_ready = 1'b0;
        bus.Branch      = 1'b0;
        bus.Jump        = 1'b0;
        bus.Zero        = 1'b0;
        model_pc  = 32'd0;
        model_cnt = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_pc_plus4", bus.pc_plus4, 32'd0);
`ifdef IFU_PERF_CNT_EN
        chk("rst_count", fetch_count, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);
        chk("first_req", {31'd0, bus.imem_req}, 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0000_0000);

        // Ack two cycles after reset release with a load-word opcode
        do_fetch(32'h8C22_0004, 1'b0, 1'b0, 1'b0, 1, 0, na);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            goto_pc(vecs[i].pc);
            do_fetch(vecs[i].ins, vecs[i].b, vecs[i].j, vecs[i].z, 1, vecs[i].rdy_dly, na);
            chk($sformatf("vec%0d_next", i), na, vecs[i].exp_next);
        end

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            do_fetch($urandom, 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 3), na);
        end

        // Reset coincident with imem_ack during FETCH
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        reset = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk("rst_ack_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_ack_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_ack_instr", bus.instr, 32'd0);
`ifdef IFU_PERF_CNT_EN
        chk("rst_ack_count", fetch_count, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);
        model_pc  = 32'd0;
        model_cnt = 32'd0;
        chk("rst_ack_valid2", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_ack_addr", bus.imem_addr, 32'h0000_0000);
        chk("rst_ack_req2", {31'd0, bus.imem_req}, 32'd1);

        // Reset during ISSUE abandons the held instruction
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk("issue_valid", {31'd0, bus.instr_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_issue_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_issue_pc_plus4", bus.pc_plus4, 32'd0);
        @(negedge clk);
        chk("rst_issue_addr", bus.imem_addr, 32'h0000_0000);

        // Three acceptances, then reset clears the counter
        for (int i = 0; i < 3; i++) begin
            do_fetch(32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 0, na);
        end
        chk("three_accept_pc", model_pc, bus.imem_addr);
`ifdef IFU_PERF_CNT_EN
        chk("count_three", fetch_count, 32'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("count_reset", fetch_count, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
